// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encodings,
// reset PC, exception NOP word and an alignment helper.
package inst_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC         = 32'hbfc0_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    // Fetch addresses must be word aligned; any low bit set raises AdEL.
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller: issues one-outstanding SRAM-like instruction requests
// for the current PC, buffers the returned word for decode and drops flushed responses.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             pc_ready_i,
    input  logic             flush_i,
    input  logic             stall_d_i,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic [WIDTH-1:0] inst_o,
    output logic [WIDTH-1:0] inst_pc_o,
    output logic             inst_valid_o,
    output logic             adel_o,
    output logic             stallF_o
);

    fetch_state_e     state_r, state_nx_s;
    logic             req_r, req_nx_s;
    logic [WIDTH-1:0] addr_r, addr_nx_s;
    logic [WIDTH-1:0] inst_r, inst_nx_s;
    logic [WIDTH-1:0] inst_pc_r, inst_pc_nx_s;
    logic             valid_r, valid_nx_s;
    logic             adel_r, adel_nx_s;
    logic             discard_r, discard_nx_s;
    logic             blocked_s;
    logic             stall_s;

    // State, bus request and decode output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            req_r     <= 1'b0;
            addr_r    <= {WIDTH{1'b0}};
            inst_r    <= {WIDTH{1'b0}};
            inst_pc_r <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            adel_r    <= 1'b0;
            discard_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            req_r     <= req_nx_s;
            addr_r    <= addr_nx_s;
            inst_r    <= inst_nx_s;
            inst_pc_r <= inst_pc_nx_s;
            valid_r   <= valid_nx_s;
            adel_r    <= adel_nx_s;
            discard_r <= discard_nx_s;
        end
    end

    // Next-state, buffer update and PC hold decision.
    always_comb begin
        state_nx_s   = state_r;
        req_nx_s     = req_r;
        addr_nx_s    = addr_r;
        inst_nx_s    = inst_r;
        inst_pc_nx_s = inst_pc_r;
        valid_nx_s   = valid_r & stall_d_i;
        adel_nx_s    = adel_r;
        discard_nx_s = discard_r;
        stall_s      = 1'b0;
        // A word still waiting for a stalled decode must not be overwritten.
        blocked_s    = valid_r & stall_d_i;

        case (state_r)
            S_IDLE: begin
                stall_s = blocked_s;
                if (flush_i) begin
                    valid_nx_s = 1'b0;
                end else if (blocked_s) begin
                    state_nx_s = S_HOLD;
                end else if (pc_ready_i) begin
                    if (addr_misaligned(pc_i[1:0])) begin
                        valid_nx_s   = 1'b1;
                        inst_nx_s    = NOP_INST;
                        inst_pc_nx_s = pc_i;
                        adel_nx_s    = 1'b1;
                        state_nx_s   = stall_d_i ? S_HOLD : S_IDLE;
                    end else begin
                        req_nx_s   = 1'b1;
                        addr_nx_s  = pc_i;
                        state_nx_s = S_REQ;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_REQ: begin
                stall_s = 1'b1;
                // The request is never withdrawn; a flush only marks its reply stale.
                discard_nx_s = discard_r | flush_i;
                if (inst_addr_ok) begin
                    req_nx_s   = 1'b0;
                    state_nx_s = S_WAIT;
                end else begin
                    state_nx_s = S_REQ;
                end
            end
            S_WAIT: begin
                stall_s = 1'b1;
                if (inst_data_ok) begin
                    discard_nx_s = 1'b0;
                    if (discard_r || flush_i) begin
                        state_nx_s = S_IDLE;
                    end else begin
                        valid_nx_s   = 1'b1;
                        inst_nx_s    = inst_rdata;
                        inst_pc_nx_s = addr_r;
                        adel_nx_s    = 1'b0;
                        state_nx_s   = stall_d_i ? S_HOLD : S_IDLE;
                    end
                end else begin
                    discard_nx_s = discard_r | flush_i;
                end
            end
            S_HOLD: begin
                stall_s = 1'b1;
                if (flush_i) begin
                    valid_nx_s = 1'b0;
                    state_nx_s = S_IDLE;
                end else if (stall_d_i) begin
                    valid_nx_s = valid_r;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            default: begin
                state_nx_s   = S_IDLE;
                req_nx_s     = 1'b0;
                valid_nx_s   = 1'b0;
                discard_nx_s = 1'b0;
            end
        endcase
    end

    // A redirect always lets the PC register load its new target.
    assign stallF_o     = stall_s & ~flush_i;
    assign inst_req     = req_r;
    assign inst_addr    = addr_r;
    assign inst_o       = inst_r;
    assign inst_pc_o    = inst_pc_r;
    assign inst_valid_o = valid_r;
    assign adel_o       = adel_r;

endmodule
